// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: default bus geometry, the read-path FSM
// state type and response codes.
// Optional feature macro: AXIL_RD_TIMEOUT_EN adds the ERR state.
package axil_pkg;

    localparam int NUMBER_MASTER  = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
`ifdef AXIL_RD_TIMEOUT_EN
        ,
        ST_ERR  = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/axil_rd_arb_mux_if.sv
// Bundle of the N master AR/R channels and the single slave AR/R channel
// seen by the read arbiter/mux. The slave modport is the arbiter's view;
// the master modport is the view of whatever drives the arbiter.
interface axil_rd_arb_mux_if #(
    parameter int NUM_MASTER = axil_pkg::NUMBER_MASTER,
    parameter int ADDR_W     = axil_pkg::AXI_ADDR_WIDTH,
    parameter int DATA_W     = axil_pkg::AXI_DATA_WIDTH
);

    // master side
    logic [NUM_MASTER-1:0][ADDR_W-1:0] m_araddr;
    logic [NUM_MASTER-1:0]             m_arvalid;
    logic [NUM_MASTER-1:0]             m_arready;
    logic [NUM_MASTER-1:0][DATA_W-1:0] m_rdata;
    logic [NUM_MASTER-1:0][1:0]        m_rresp;
    logic [NUM_MASTER-1:0]             m_rvalid;
    logic [NUM_MASTER-1:0]             m_rready;

    // slave side
    logic [ADDR_W-1:0]                 s_araddr;
    logic                              s_arvalid;
    logic                              s_arready;
    logic [DATA_W-1:0]                 s_rdata;
    logic [1:0]                        s_rresp;
    logic                              s_rvalid;
    logic                              s_rready;

    modport slave (
        input  m_araddr, m_arvalid, m_rready,
        input  s_arready, s_rdata, s_rresp, s_rvalid,
        output m_arready, m_rdata, m_rresp, m_rvalid,
        output s_araddr, s_arvalid, s_rready
    );

    modport master (
        output m_araddr, m_arvalid, m_rready,
        output s_arready, s_rdata, s_rresp, s_rvalid,
        input  m_arready, m_rdata, m_rresp, m_rvalid,
        input  s_araddr, s_arvalid, s_rready
    );

endinterface

// File: rtl/axil_rr_arbiter.sv
// Combinational round-robin picker: searches req from index last+1 upward
// with wrap-around and returns a one-hot winner (zero when no request).
module axil_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     winner
);

    // first requester after the previous winner gets the grant
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        winner = '0;
        for (int k = 1; k <= N; k++) begin
            int               pos;
            logic [IDX_W-1:0] sel;
            pos = int'(last) + k;
            if (pos >= N) pos = pos - N;
            sel = IDX_W'(pos);
            if (winner == '0 && req[sel]) winner[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/axil_rd_arb_mux.sv
// N-to-1 AXI-Lite read arbiter/mux with a single outstanding transaction.
// IDLE arbitrates round-robin, ADDR forwards the AR beat of the granted
// master, DATA routes the R beat back. All channel outputs are
// combinational from registered state/grant plus the routed inputs.
// Optional feature macro: AXIL_RD_TIMEOUT_EN -- aborts a DATA phase that
// waits TIMEOUT_CYC cycles for s_rvalid and answers the master with SLVERR.
module axil_rd_arb_mux
    import axil_pkg::*;
#(
    parameter int NUM_MASTER  = NUMBER_MASTER,
    parameter int ADDR_W      = AXI_ADDR_WIDTH,
    parameter int DATA_W      = AXI_DATA_WIDTH,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axil_rd_arb_mux_if.slave      bus,
    output logic [NUM_MASTER-1:0] grant
);

    localparam int IDX_W = $clog2(NUM_MASTER);

    state_t                state;
    state_t                state_next;
    logic [NUM_MASTER-1:0] winner;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      g_idx;
    logic [IDX_W-1:0]      last;
    logic                  txn_done;

    axil_rr_arbiter #(
        .N     (NUM_MASTER),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (bus.m_arvalid),
        .last   (last),
        .winner (winner)
    );

    // index form of the one-hot winner, kept alongside the grant for muxing
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (winner[i]) win_idx = IDX_W'(i);
        end
    end

`ifdef AXIL_RD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             timeout_hit;

    assign timeout_hit = (state == ST_DATA) && !bus.s_rvalid &&
                         (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    assign txn_done = ((state == ST_DATA) && bus.s_rvalid && bus.s_rready) ||
                      ((state == ST_ERR) && bus.m_rready[g_idx]);

    // count DATA cycles without s_rvalid; restart on every state change
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            to_cnt <= '0;
        end else if (state_next != state) begin
            to_cnt <= '0;
        end else if (state == ST_DATA && !bus.s_rvalid) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic cfg_unused;

    // timeout configuration has no function in this build
    assign cfg_unused = ^{TIMEOUT_CYC, RESP_SLVERR};

    assign txn_done = (state == ST_DATA) && bus.s_rvalid && bus.s_rready;
`endif

    // state register
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (|bus.m_arvalid)                   state_next = ST_ADDR;
            ST_ADDR: if (bus.s_arvalid && bus.s_arready)   state_next = ST_DATA;
`ifdef AXIL_RD_TIMEOUT_EN
            ST_DATA: begin
                if (bus.s_rvalid && bus.s_rready)          state_next = ST_IDLE;
                else if (timeout_hit)                      state_next = ST_ERR;
            end
            ST_ERR:  if (bus.m_rready[g_idx])              state_next = ST_IDLE;
`else
            ST_DATA: if (bus.s_rvalid && bus.s_rready)     state_next = ST_IDLE;
`endif
            default:                                       state_next = ST_IDLE;
        endcase
    end

    // grant is captured at arbitration and held until the R handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant <= '0;
            g_idx <= '0;
            last  <= IDX_W'(NUM_MASTER - 1);
        end else if (state == ST_IDLE && |bus.m_arvalid) begin
            grant <= winner;
            g_idx <= win_idx;
        end else if (txn_done) begin
            grant <= '0;
            last  <= g_idx;
        end
    end

    // channel routing between the granted master and the slave
    always_comb begin
        bus.m_arready = '0;
        bus.m_rdata   = '0;
        bus.m_rresp   = '0;
        bus.m_rvalid  = '0;
        bus.s_araddr  = '0;
        bus.s_arvalid = 1'b0;
`ifdef AXIL_RD_TIMEOUT_EN
        // drain any late beat from a timed-out slave while idle
        bus.s_rready  = (state == ST_IDLE) && aresetn;
`else
        bus.s_rready  = 1'b0;
`endif
        case (state)
            ST_ADDR: begin
                bus.s_araddr         = bus.m_araddr[g_idx];
                bus.s_arvalid        = bus.m_arvalid[g_idx];
                bus.m_arready[g_idx] = bus.s_arready;
            end
            ST_DATA: begin
                bus.m_rdata[g_idx]   = bus.s_rdata;
                bus.m_rresp[g_idx]   = bus.s_rresp;
                bus.m_rvalid[g_idx]  = bus.s_rvalid;
                bus.s_rready         = bus.m_rready[g_idx];
            end
`ifdef AXIL_RD_TIMEOUT_EN
            ST_ERR: begin
                bus.m_rvalid[g_idx]  = 1'b1;
                bus.m_rresp[g_idx]   = RESP_SLVERR;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axil_rd_arb_mux.sv
// Self-checking bench for axil_rd_arb_mux (4 masters, 32-bit bus).
// The bench plays all masters and the slave; expected grants come from a
// round-robin model of the arbitration rule, expected data from the
// values the bench itself drives.
// Optional feature macro: AXIL_RD_TIMEOUT_EN enables the timeout test.
module tb_axil_rd_arb_mux;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
`ifdef AXIL_RD_TIMEOUT_EN
    localparam logic IDLE_RREADY = 1'b1;
`else
    localparam logic IDLE_RREADY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [NM-1:0] grant;

    int checks = 0;
    int errors = 0;
    int model_last;
    logic [AW-1:0] addr_tab [NM];

    axil_rd_arb_mux_if #(.NUM_MASTER(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    axil_rd_arb_mux #(
        .NUM_MASTER  (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .aclk    (clk),
        .aresetn (aresetn),
        .bus     (bus.slave),
        .grant   (grant)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // round-robin rule: first requester above the previous winner, wrapping
    function automatic int rr_pick(input logic [NM-1:0] mask, input int last);
        for (int k = 1; k <= NM; k++) begin
            int i;
            i = (last + k) % NM;
            if (mask[i]) return i;
        end
        return 0;
    endfunction

    task automatic reset_dut();
        aresetn        = 1'b0;
        bus.m_arvalid  = '0;
        bus.m_araddr   = '0;
        bus.m_rready   = '0;
        bus.s_arready  = 1'b0;
        bus.s_rvalid   = 1'b0;
        bus.s_rdata    = '0;
        bus.s_rresp    = '0;
        repeat (2) step();
        aresetn    = 1'b1;
        model_last = NM - 1;
    endtask

    // One full transaction from IDLE back to IDLE with checks at every cycle.
    task automatic serve_one(input logic [NM-1:0] mask, input int ar_wait,
                             input int r_wait, input int rr_wait,
                             input logic [NM-1:0] keep_rr,
                             input logic [DW-1:0] rdata, input logic [1:0] rresp,
                             output logic [NM-1:0] obs_grant);
        int g;
        logic [NM-1:0]         oh;
        logic [NM-1:0][DW-1:0] exp_rd;
        logic [NM-1:0][1:0]    exp_rr;
        g      = rr_pick(mask, model_last);
        oh     = NM'(1) << g;
        exp_rd = '0;
        exp_rd[g] = rdata;
        exp_rr = '0;
        exp_rr[g] = rresp;
        for (int i = 0; i < NM; i++) bus.m_araddr[i] = addr_tab[i];
        bus.m_arvalid = mask;
        bus.m_rready  = keep_rr;
        #1;
        checks++;
        if ({grant, bus.s_arvalid, bus.m_arready, bus.m_rvalid} !== {NM'(0), 1'b0, NM'(0), NM'(0)}) begin
            errors++;
            $display("FAIL idle_outputs: grant=%b s_arvalid=%b m_arready=%b m_rvalid=%b, required all zero",
                     grant, bus.s_arvalid, bus.m_arready, bus.m_rvalid);
        end
        step();
        obs_grant = grant;
        checks++;
        if (grant !== oh) begin
            errors++;
            $display("FAIL arb_grant: got %b, required %b (mask %b)", grant, oh, mask);
        end
        for (int k = 0; k < ar_wait; k++) begin
            bus.s_arready = 1'b0;
            #1;
            checks++;
            if ({bus.s_arvalid, bus.s_araddr, bus.m_arready, grant} !== {1'b1, addr_tab[g], NM'(0), oh}) begin
                errors++;
                $display("FAIL ar_stall: s_arvalid=%b s_araddr=%h m_arready=%b grant=%b, required 1 %h 0 %b",
                         bus.s_arvalid, bus.s_araddr, bus.m_arready, grant, addr_tab[g], oh);
            end
            step();
        end
        bus.s_arready = 1'b1;
        #1;
        checks++;
        if ({bus.s_arvalid, bus.s_araddr, bus.m_arready, bus.s_rready} !== {1'b1, addr_tab[g], oh, 1'b0}) begin
            errors++;
            $display("FAIL ar_handshake: s_arvalid=%b s_araddr=%h m_arready=%b s_rready=%b, required 1 %h %b 0",
                     bus.s_arvalid, bus.s_araddr, bus.m_arready, bus.s_rready, addr_tab[g], oh);
        end
        step();
        bus.s_arready    = 1'b0;
        bus.m_arvalid[g] = 1'b0;
        for (int k = 0; k < r_wait; k++) begin
            bus.s_rvalid = 1'b0;
            bus.m_rready = NM'($urandom) | keep_rr;
            #1;
            checks++;
            if ({bus.s_arvalid, bus.s_araddr, bus.m_rvalid, bus.s_rready, grant} !==
                {1'b0, AW'(0), NM'(0), bus.m_rready[g], oh}) begin
                errors++;
                $display("FAIL r_wait: s_arvalid=%b s_araddr=%h m_rvalid=%b s_rready=%b grant=%b, required 0 0 0 %b %b",
                         bus.s_arvalid, bus.s_araddr, bus.m_rvalid, bus.s_rready, grant, bus.m_rready[g], oh);
            end
            step();
        end
        bus.s_rvalid = 1'b1;
        bus.s_rdata  = rdata;
        bus.s_rresp  = rresp;
        for (int k = 0; k < rr_wait; k++) begin
            bus.m_rready = (NM'($urandom) | keep_rr) & ~oh;
            #1;
            checks++;
            if ({bus.m_rvalid, bus.m_rdata, bus.m_rresp, bus.s_rready, grant} !== {oh, exp_rd, exp_rr, 1'b0, oh}) begin
                errors++;
                $display("FAIL r_stall: m_rvalid=%b m_rdata=%h m_rresp=%b s_rready=%b grant=%b, required %b %h %b 0 %b",
                         bus.m_rvalid, bus.m_rdata, bus.m_rresp, bus.s_rready, grant, oh, exp_rd, exp_rr, oh);
            end
            step();
        end
        bus.m_rready = NM'($urandom) | keep_rr | oh;
        #1;
        checks++;
        if ({bus.m_rvalid, bus.m_rdata, bus.m_rresp, bus.s_rready, grant} !== {oh, exp_rd, exp_rr, 1'b1, oh}) begin
            errors++;
            $display("FAIL r_handshake: m_rvalid=%b m_rdata=%h m_rresp=%b s_rready=%b grant=%b, required %b %h %b 1 %b",
                     bus.m_rvalid, bus.m_rdata, bus.m_rresp, bus.s_rready, grant, oh, exp_rd, exp_rr, oh);
        end
        step();
        bus.s_rvalid = 1'b0;
        bus.m_rready = keep_rr;
        model_last   = g;
        #1;
        checks++;
        if ({grant, bus.m_rvalid, bus.s_arvalid, bus.s_rready} !== {NM'(0), NM'(0), 1'b0, IDLE_RREADY}) begin
            errors++;
            $display("FAIL back_to_idle: grant=%b m_rvalid=%b s_arvalid=%b s_rready=%b, required 0 0 0 %b",
                     grant, bus.m_rvalid, bus.s_arvalid, bus.s_rready, IDLE_RREADY);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #1;
        checks++;
        if ({grant, bus.m_arready, bus.m_rvalid, bus.s_arvalid, bus.s_rready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b m_arready=%b m_rvalid=%b s_arvalid=%b s_rready=%b, required all zero",
                     grant, bus.m_arready, bus.m_rvalid, bus.s_arvalid, bus.s_rready);
        end
        reset_dut();
        checks++;
        if ({grant, bus.s_rready} !== {NM'(0), IDLE_RREADY}) begin
            errors++;
            $display("FAIL reset_release: grant=%b s_rready=%b, required 0 %b", grant, bus.s_rready, IDLE_RREADY);
        end
    endtask

    task automatic test_single();
        logic [NM-1:0] g;
        addr_tab[1] = 32'h0000_0040;
        serve_one(4'b0010, 0, 0, 0, '0, 32'hDEAD_BEEF, 2'b00, g);
        checks++;
        if (g !== 4'b0010) begin
            errors++;
            $display("FAIL single_grant: got %b, required 0010", g);
        end
    endtask

    task automatic test_contention();
        int order [4] = '{0, 2, 3, 0};
        logic [NM-1:0] g;
        reset_dut();
        for (int i = 0; i < NM; i++) addr_tab[i] = AW'($urandom);
        for (int t = 0; t < 4; t++) begin
            serve_one(4'b1101, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                      '0, DW'($urandom), 2'($urandom), g);
            checks++;
            if (g !== NM'(1) << order[t]) begin
                errors++;
                $display("FAIL contention_order[%0d]: got %b, required master %0d", t, g, order[t]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NM-1:0] g;
        addr_tab[2] = 32'h1234_5678;
        serve_one(4'b0100, 5, 0, 3, '0, 32'hCAFE_F00D, 2'b01, g);
    endtask

    task automatic test_isolation();
        logic [NM-1:0] g;
        serve_one(4'b0001, 1, 2, 2, 4'b0100, DW'($urandom), 2'b00, g);
    endtask

    task automatic test_back_to_back();
        logic [NM-1:0] g;
        for (int t = 0; t < 2; t++) begin
            serve_one(4'b1000, 0, 0, 0, '0, DW'($urandom), 2'b00, g);
            checks++;
            if (g !== 4'b1000) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b, required 1000", t, g);
            end
        end
    endtask

    task automatic test_random();
        logic [NM-1:0] g;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NM; i++) addr_tab[i] = AW'($urandom);
            serve_one(NM'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 4),
                      $urandom_range(0, 3), '0, DW'($urandom), 2'($urandom), g);
        end
    endtask

    task automatic test_reset_in_data();
        logic [NM-1:0] g;
        bus.m_arvalid = 4'b0100;
        step();
        bus.s_arready = 1'b1;
        step();
        bus.s_arready = 1'b0;
        bus.m_arvalid = '0;
        bus.s_rvalid  = 1'b1;
        bus.m_rready  = '0;
        #1;
        checks++;
        if ({grant, bus.m_rvalid} !== {4'b0100, 4'b0100}) begin
            errors++;
            $display("FAIL pre_reset_data: grant=%b m_rvalid=%b, required 0100 0100", grant, bus.m_rvalid);
        end
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({grant, bus.m_arready, bus.m_rvalid, bus.s_arvalid, bus.s_rready} !== '0) begin
            errors++;
            $display("FAIL reset_mid_data: grant=%b m_arready=%b m_rvalid=%b s_arvalid=%b s_rready=%b, required all zero",
                     grant, bus.m_arready, bus.m_rvalid, bus.s_arvalid, bus.s_rready);
        end
        bus.s_rvalid = 1'b0;
        step();
        aresetn    = 1'b1;
        model_last = NM - 1;
        serve_one(4'b1111, 0, 1, 0, '0, DW'($urandom), 2'b00, g);
        checks++;
        if (g !== 4'b0001) begin
            errors++;
            $display("FAIL reset_next_winner: got %b, required 0001", g);
        end
    endtask

`ifdef AXIL_RD_TIMEOUT_EN
    task automatic test_timeout();
        logic [NM-1:0] g;
        bus.m_arvalid = 4'b0010;
        bus.s_rdata   = 32'hFFFF_FFFF;
        step();
        bus.s_arready = 1'b1;
        step();
        bus.s_arready = 1'b0;
        bus.m_arvalid = '0;
        bus.m_rready  = '0;
        for (int k = 0; k < TO; k++) begin
            #1;
            checks++;
            if ({bus.m_rvalid, grant} !== {NM'(0), 4'b0010}) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: m_rvalid=%b grant=%b, required 0000 0010", k, bus.m_rvalid, grant);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({bus.m_rvalid, bus.m_rresp[1], bus.m_rdata[1], bus.s_rready} !== {4'b0010, 2'b10, DW'(0), 1'b0}) begin
                errors++;
                $display("FAIL timeout_err: m_rvalid=%b rresp=%b rdata=%h s_rready=%b, required 0010 10 0 0",
                         bus.m_rvalid, bus.m_rresp[1], bus.m_rdata[1], bus.s_rready);
            end
            if (k == 0) step();
        end
        bus.m_rready = 4'b0010;
        step();
        bus.m_rready = '0;
        model_last   = 1;
        #1;
        checks++;
        if ({grant, bus.m_rvalid, bus.s_rready} !== {NM'(0), NM'(0), 1'b1}) begin
            errors++;
            $display("FAIL timeout_idle: grant=%b m_rvalid=%b s_rready=%b, required 0 0 1", grant, bus.m_rvalid, bus.s_rready);
        end
        serve_one(4'b0110, 0, 1, 1, '0, DW'($urandom), 2'b00, g);
        checks++;
        if (g !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_next: got %b, required 0100", g);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NM; i++) addr_tab[i] = '0;
        reset_dut();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_isolation();
        test_back_to_back();
        test_random();
        test_reset_in_data();
`ifdef AXIL_RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_rd_arb_mux.md
AXIL_RD_ARB_MUX -- requirements
Module: axil_rd_arb_mux

Interface
REQ-001 SHALL have parameter NUM_MASTER, default NUMBER_MASTER, number of read masters (2..16).
REQ-002 SHALL have parameter ADDR_W, default AXI_ADDR_WIDTH, address width.
REQ-003 SHALL have parameter DATA_W, default AXI_DATA_WIDTH, read data width (32 or 64).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 256, R-wait limit in cycles (used only with the timeout feature).
REQ-005 SHALL have port aclk, input, 1, sole clock; all state on its rising edge.
REQ-006 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports m_araddr [NUM_MASTER] x ADDR_W input, m_arvalid NUM_MASTER input, and m_arready NUM_MASTER output: the master AR channels.
REQ-008 SHALL have ports m_rdata [NUM_MASTER] x DATA_W output, m_rresp [NUM_MASTER] x 2 output, m_rvalid NUM_MASTER output, and m_rready NUM_MASTER input: the master R channels.
REQ-009 SHALL have ports s_araddr ADDR_W output, s_arvalid 1 output, and s_arready 1 input: the slave AR channel.
REQ-010 SHALL have ports s_rdata DATA_W input, s_rresp 2 input, s_rvalid 1 input, and s_rready 1 output: the slave R channel.
REQ-011 SHALL have port grant, output, NUM_MASTER, one-hot registered grant; all zero when idle.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR and DATA, plus ERR when the timeout feature is compiled in.
REQ-013 IDLE: when any m_arvalid is high, SHALL choose a winner round-robin, searching from index last+1 upward with wrap-around; SHALL register a one-hot grant and move to ADDR on the next edge (1 cycle of arbitration latency).
REQ-014 ADDR: SHALL drive s_araddr/s_arvalid from the granted master and route s_arready to m_arready[g]; on s_arvalid&&s_arready SHALL move to DATA.
REQ-015 DATA: SHALL route s_rdata/s_rresp/s_rvalid to master g and m_rready[g] to s_rready; on s_rvalid&&s_rready SHALL move to IDLE, set last=g, and clear grant.
REQ-016 Non-granted masters SHALL see m_arready=0, m_rvalid=0, m_rdata=0 and m_rresp=0 in every cycle.
REQ-017 Outside ADDR, s_arvalid SHALL be 0 and s_araddr SHALL be 0; outside DATA, s_rready SHALL be 0 (except as stated in REQ-024).
REQ-018 Exactly one transaction SHALL be outstanding, and grant SHALL remain stable from entry to ADDR until the R handshake.
REQ-019 Requests arriving while busy SHALL wait; a single requester SHALL win back-to-back with one IDLE cycle between transactions.
REQ-020 All master-side and slave-side outputs SHALL be combinational from the registered grant/state and the routed inputs; no datapath registers.

Reset
REQ-021 On aresetn=0, SHALL asynchronously enter IDLE with grant=0, last=NUM_MASTER-1 (so master 0 wins first) and timeout counter=0; all valid/ready outputs SHALL be 0.
REQ-022 A reset asserted mid-transaction SHALL abort it without any response to the master.

Configuration
REQ-023 Macro AXIL_RD_TIMEOUT_EN, when defined: SHALL count cycles in DATA while s_rvalid=0; on reaching TIMEOUT_CYC SHALL enter ERR and drive m_rvalid[g]=1, m_rresp[g]=2'b10 (SLVERR) and m_rdata[g]=0 with s_rready=0; on m_rready[g] SHALL return to IDLE with last=g; the counter SHALL reset on state entry.
REQ-024 With AXIL_RD_TIMEOUT_EN defined, s_rready SHALL be 1 in IDLE so that late slave beats are discarded.
REQ-025 Without AXIL_RD_TIMEOUT_EN, ERR, the counter and TIMEOUT_CYC logic SHALL be absent, and DATA SHALL wait indefinitely.

Structure
REQ-026 NUMBER_MASTER, AXI_ADDR_WIDTH, AXI_DATA_WIDTH, the state enum type and the RESP_SLVERR constant SHALL reside in axil_pkg.
REQ-027 Round-robin selection SHALL be a sub-module axil_rr_arbiter (inputs req and last; output one-hot winner), reusable by the write path.

Verification
REQ-028 Single request: master 1 asserts arvalid with addr 0x40; the slave returns rdata 0xDEADBEEF and rresp OKAY -> grant=0b0010 one cycle later, and only master 1 sees rvalid with 0xDEADBEEF.
REQ-029 Contention: masters 0, 2 and 3 request continuously (NUM_MASTER=4) -> grant order 0, 2, 3, 0, with exactly one transaction at a time.
REQ-030 Backpressure: hold s_arready=0 for 5 cycles, then hold m_rready=0 for 3 cycles -> s_arvalid and s_araddr stay stable, grant is unchanged, and the return to IDLE follows the R handshake.
REQ-031 Isolation: master 2 holds rready=1 while master 0 is granted -> master 2 sees rvalid=0 and rdata=0 throughout.
REQ-032 Timeout (macro defined, TIMEOUT_CYC=16): slave never asserts rvalid -> after 16 DATA cycles master g receives rresp=2'b10 and rdata=0; the next request is served.
REQ-033 Reset in DATA: assert aresetn=0 for 1 cycle -> grant=0, all valid/ready outputs are 0 immediately, and the next winner is master 0.
